gcm_instance_sequencer: RTL and testbench

Control block that sequences one AES-GCM instance through the shared GHASH/tag stage and the CTR keystream path. It accepts a job descriptor of AAD and plaintext bit lengths, then passes upstream 128-bit blocks downstream in a fixed order: a new-instance strobe, the AAD blocks, the text blocks, and the length block. It drives the block-type select and the CTR increment, and reports the tag as ready after a fixed pipeline latency. It sits between the block source and the GHASH/tag pipeline stage.

---
 rtl/gcm_pkg.sv | 26 ++
 rtl/gcm_instance_sequencer_if.sv | 34 +++
 rtl/gcm_block_counter.sv | 37 +++
 rtl/gcm_instance_sequencer.sv | 154 +++++++++++++++
 tb/tb_gcm_instance_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gcm_pkg.sv
// Shared types, constants and helpers for the GCM instance sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gcm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_AAD,
    ST_TEXT,
    ST_LEN,
    ST_WAIT_TAG
  } seq_state_t;

  localparam logic [1:0] GHASH_SEL_AAD  = 2'd0;
  localparam logic [1:0] GHASH_SEL_TEXT = 2'd1;
  localparam logic [1:0] GHASH_SEL_LEN  = 2'd2;

  // Number of 128-bit blocks covering a bit length. Callers pass a
  // zero-extended length of at most 63 significant bits, so the +127
  // cannot wrap.
  function automatic logic [63:0] blocks_of(input logic [63:0] bits);
    return (bits + 64'd127) >> 7;
  endfunction

endpackage

// File: rtl/gcm_instance_sequencer_if.sv
// Bundle of descriptor, upstream block and GHASH/CTR/tag signals around the sequencer.
// Latency: n/a (wires only).
// Backpressure: descriptor and block channels are valid/ready; downstream has none.
// Ports: master = block source / environment side, slave = sequencer side.
interface gcm_instance_sequencer_if #(
  parameter int LEN_W = 32
);
  logic              i_desc_valid;
  logic              o_desc_ready;
  logic [LEN_W-1:0]  i_aad_bits;
  logic [LEN_W-1:0]  i_txt_bits;
  logic              i_blk_valid;
  logic              o_blk_ready;
  logic [0:127]      i_blk;          // bit 0 = MSB
  logic              o_new_instance;
  logic              o_ghash_valid;
  logic [1:0]        o_ghash_sel;
  logic [0:127]      o_ghash_block;  // bit 0 = MSB
  logic              o_ctr_en;
  logic              o_tag_ready;
  logic              o_busy;

  modport master (
    output i_desc_valid, i_aad_bits, i_txt_bits, i_blk_valid, i_blk,
    input  o_desc_ready, o_blk_ready, o_new_instance, o_ghash_valid,
           o_ghash_sel, o_ghash_block, o_ctr_en, o_tag_ready, o_busy
  );

  modport slave (
    input  i_desc_valid, i_aad_bits, i_txt_bits, i_blk_valid, i_blk,
    output o_desc_ready, o_blk_ready, o_new_instance, o_ghash_valid,
           o_ghash_sel, o_ghash_block, o_ctr_en, o_tag_ready, o_busy
  );
endinterface

// File: rtl/gcm_block_counter.sv
// Loadable down-counter of remaining blocks in the current AAD/TEXT phase.
// Latency: load/decrement take effect on the next edge; last is combinational from the count.
// Backpressure: none; decrements only when the caller reports a consumed beat.
// Ports: clk/rst; load + load_val (priority over dec); dec; last = one block remaining.
module gcm_block_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/gcm_instance_sequencer.sv
// Sequences one AES-GCM instance: new-instance strobe, AAD, TEXT, LEN block, tag-ready pulse.
// Latency: zero-cycle block pass-through; tag ready TAG_LAT cycles after the LEN beat.
// Backpressure: blocks accepted every AAD/TEXT cycle (bubbles give no beat); GHASH is never stalled.
// Ports: clk, rst (async active-high), bus (slave modport of gcm_instance_sequencer_if).
module gcm_instance_sequencer
  import gcm_pkg::*;
#(
  parameter int LEN_W   = 32,
  parameter int TAG_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  gcm_instance_sequencer_if.slave  bus
);

  localparam int WAIT_W = (TAG_LAT > 1) ? $clog2(TAG_LAT) : 1;

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] aad_q, aad_d;
  logic [LEN_W-1:0] txt_q, txt_d;
  logic [LEN_W-1:0] na_q, na_d;
  logic [LEN_W-1:0] nt_q, nt_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;

  logic             cnt_load;
  logic [LEN_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_last;

  gcm_block_counter #(.W(LEN_W)) u_blk_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    aad_d        = aad_q;
    txt_d        = txt_q;
    na_d         = na_q;
    nt_d         = nt_q;
    wcnt_d       = wcnt_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_desc_valid) begin
          aad_d   = bus.i_aad_bits;
          txt_d   = bus.i_txt_bits;
          na_d    = LEN_W'(blocks_of(64'(bus.i_aad_bits)));
          nt_d    = LEN_W'(blocks_of(64'(bus.i_txt_bits)));
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (na_q != '0) begin
          cnt_load     = 1'b1;
          cnt_load_val = na_q;
          state_d      = ST_AAD;
        end else if (nt_q != '0) begin
          cnt_load     = 1'b1;
          cnt_load_val = nt_q;
          state_d      = ST_TEXT;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_AAD: begin
        if (bus.i_blk_valid) begin
          if (cnt_last) begin
            // Reload for TEXT on the same edge so there is no gap between phases;
            // loading nt=0 leaves the counter cleared when TEXT is skipped.
            cnt_load     = 1'b1;
            cnt_load_val = nt_q;
            state_d      = (nt_q != '0) ? ST_TEXT : ST_LEN;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      ST_TEXT: begin
        if (bus.i_blk_valid) begin
          cnt_dec = 1'b1;
          if (cnt_last) begin
            state_d = ST_LEN;
          end
        end
      end
      ST_LEN: begin
        wcnt_d  = '0;
        state_d = ST_WAIT_TAG;
      end
      ST_WAIT_TAG: begin
        if (wcnt_q == WAIT_W'(TAG_LAT - 1)) begin
          wcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      aad_q   <= '0;
      txt_q   <= '0;
      na_q    <= '0;
      nt_q    <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      aad_q   <= aad_d;
      txt_q   <= txt_d;
      na_q    <= na_d;
      nt_q    <= nt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  logic in_aad, in_text, in_len, in_data;
  assign in_aad  = (state_q == ST_AAD);
  assign in_text = (state_q == ST_TEXT);
  assign in_len  = (state_q == ST_LEN);
  assign in_data = in_aad || in_text;

  assign bus.o_desc_ready   = (state_q == ST_IDLE);
  assign bus.o_busy         = (state_q != ST_IDLE);
  assign bus.o_new_instance = (state_q == ST_START);
  assign bus.o_blk_ready    = in_data;
  assign bus.o_ghash_valid  = (in_data && bus.i_blk_valid) || in_len;
  assign bus.o_ctr_en       = in_text && bus.i_blk_valid;
  assign bus.o_tag_ready    = (state_q == ST_WAIT_TAG) && (wcnt_q == WAIT_W'(TAG_LAT - 1));

  always_comb begin
    bus.o_ghash_sel   = GHASH_SEL_AAD;
    bus.o_ghash_block = '0;
    if (in_data) begin
      bus.o_ghash_sel   = in_text ? GHASH_SEL_TEXT : GHASH_SEL_AAD;
      bus.o_ghash_block = bus.i_blk;
    end else if (in_len) begin
      bus.o_ghash_sel   = GHASH_SEL_LEN;
      bus.o_ghash_block = {64'(aad_q), 64'(txt_q)};
    end
  end

endmodule

// File: tb/tb_gcm_instance_sequencer.sv
// Directed bench for gcm_instance_sequencer with hand-computed expectations.
// Latency: checks are taken 2 time units after each rising edge.
// Backpressure: exercises always-valid and alternating-valid block streams.
module tb_gcm_instance_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gcm_instance_sequencer_if #(.LEN_W(32)) bus ();

  gcm_instance_sequencer #(.LEN_W(32), .TAG_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, drive the block channel, let outputs settle.
  task automatic cyc(input logic v, input logic [127:0] d);
    @(posedge clk);
    #1;
    bus.i_blk_valid = v;
    bus.i_blk       = d;
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] t);
    bus.i_desc_valid = 1'b1;
    bus.i_aad_bits   = a;
    bus.i_txt_bits   = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_desc_valid = 1'b0;
    bus.i_aad_bits   = '0;
    bus.i_txt_bits   = '0;
    bus.i_blk_valid  = 1'b0;
    bus.i_blk        = '0;

    // Reset state
    #12;
    chk("rst_desc_ready",   128'(bus.o_desc_ready),   128'd1);
    chk("rst_busy",         128'(bus.o_busy),         128'd0);
    chk("rst_ghash_valid",  128'(bus.o_ghash_valid),  128'd0);
    chk("rst_new_instance", 128'(bus.o_new_instance), 128'd0);
    chk("rst_tag_ready",    128'(bus.o_tag_ready),    128'd0);
    chk("rst_blk_ready",    128'(bus.o_blk_ready),    128'd0);
    chk("rst_ctr_en",       128'(bus.o_ctr_en),       128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Job 1: aad=128, txt=256, blocks always valid
    present(32'd128, 32'd256);
    bus.i_blk_valid = 1'b1;
    bus.i_blk       = 128'hA0A0_0000_0000_0000_0000_0000_0000_0001;
    #1;
    chk("j1_desc_ready", 128'(bus.o_desc_ready), 128'd1);
    cyc(1'b1, 128'hA0A0_0000_0000_0000_0000_0000_0000_0001);
    bus.i_desc_valid = 1'b0;
    chk("j1_new_inst",     128'(bus.o_new_instance), 128'd1);
    chk("j1_start_gvalid", 128'(bus.o_ghash_valid),  128'd0);
    chk("j1_start_bready", 128'(bus.o_blk_ready),    128'd0);
    chk("j1_start_busy",   128'(bus.o_busy),         128'd1);
    cyc(1'b1, 128'hA0A0_0000_0000_0000_0000_0000_0000_0001);
    chk("j1_aad_gvalid", 128'(bus.o_ghash_valid), 128'd1);
    chk("j1_aad_sel",    128'(bus.o_ghash_sel),   128'd0);
    chk("j1_aad_blk",    128'(bus.o_ghash_block), 128'hA0A0_0000_0000_0000_0000_0000_0000_0001);
    chk("j1_aad_ctr",    128'(bus.o_ctr_en),      128'd0);
    chk("j1_aad_newi",   128'(bus.o_new_instance), 128'd0);
    cyc(1'b1, 128'hB1B1_1111_2222_3333_4444_5555_6666_7777);
    chk("j1_t0_sel", 128'(bus.o_ghash_sel),   128'd1);
    chk("j1_t0_blk", 128'(bus.o_ghash_block), 128'hB1B1_1111_2222_3333_4444_5555_6666_7777);
    chk("j1_t0_ctr", 128'(bus.o_ctr_en),      128'd1);
    cyc(1'b1, 128'hB2B2_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE);
    chk("j1_t1_sel", 128'(bus.o_ghash_sel),   128'd1);
    chk("j1_t1_blk", 128'(bus.o_ghash_block), 128'hB2B2_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE);
    chk("j1_t1_ctr", 128'(bus.o_ctr_en),      128'd1);
    cyc(1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    chk("j1_len_gvalid", 128'(bus.o_ghash_valid), 128'd1);
    chk("j1_len_sel",    128'(bus.o_ghash_sel),   128'd2);
    chk("j1_len_blk",    128'(bus.o_ghash_block), 128'h0000_0000_0000_0080_0000_0000_0000_0100);
    chk("j1_len_bready", 128'(bus.o_blk_ready),   128'd0);
    chk("j1_len_ctr",    128'(bus.o_ctr_en),      128'd0);
    cyc(1'b1, 128'd0);
    chk("j1_w1_tag",    128'(bus.o_tag_ready),   128'd0);
    chk("j1_w1_gvalid", 128'(bus.o_ghash_valid), 128'd0);
    cyc(1'b1, 128'd0);
    chk("j1_tag",        128'(bus.o_tag_ready),  128'd1);
    chk("j1_tag_dready", 128'(bus.o_desc_ready), 128'd0);
    cyc(1'b1, 128'd0);
    chk("j1_idle_dready", 128'(bus.o_desc_ready), 128'd1);
    chk("j1_idle_busy",   128'(bus.o_busy),       128'd0);
    chk("j1_idle_tag",    128'(bus.o_tag_ready),  128'd0);

    // Job 2: aad=0, txt=0
    present(32'd0, 32'd0);
    cyc(1'b1, 128'h1234);
    bus.i_desc_valid = 1'b0;
    chk("j2_new_inst", 128'(bus.o_new_instance), 128'd1);
    cyc(1'b1, 128'h1234);
    chk("j2_len_gvalid", 128'(bus.o_ghash_valid), 128'd1);
    chk("j2_len_sel",    128'(bus.o_ghash_sel),   128'd2);
    chk("j2_len_blk",    128'(bus.o_ghash_block), 128'd0);
    chk("j2_len_bready", 128'(bus.o_blk_ready),   128'd0);
    cyc(1'b1, 128'h1234);
    chk("j2_w1_tag",    128'(bus.o_tag_ready), 128'd0);
    chk("j2_w1_bready", 128'(bus.o_blk_ready), 128'd0);
    cyc(1'b1, 128'h1234);
    chk("j2_tag", 128'(bus.o_tag_ready), 128'd1);
    cyc(1'b0, 128'd0);
    chk("j2_idle_dready", 128'(bus.o_desc_ready), 128'd1);

    // Job 3: aad=130, txt=1 -> 2 AAD beats, 1 TEXT beat, partial blocks unchanged
    present(32'd130, 32'd1);
    cyc(1'b1, 128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF);
    bus.i_desc_valid = 1'b0;
    chk("j3_new_inst", 128'(bus.o_new_instance), 128'd1);
    cyc(1'b1, 128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF);
    chk("j3_a0_sel", 128'(bus.o_ghash_sel),   128'd0);
    chk("j3_a0_blk", 128'(bus.o_ghash_block), 128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF);
    cyc(1'b1, 128'hC000_0000_0000_0000_0000_0000_0000_0000);
    chk("j3_a1_sel", 128'(bus.o_ghash_sel),   128'd0);
    chk("j3_a1_blk", 128'(bus.o_ghash_block), 128'hC000_0000_0000_0000_0000_0000_0000_0000);
    cyc(1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    chk("j3_t0_sel", 128'(bus.o_ghash_sel),   128'd1);
    chk("j3_t0_blk", 128'(bus.o_ghash_block), 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    chk("j3_t0_ctr", 128'(bus.o_ctr_en),      128'd1);
    cyc(1'b1, 128'hDEAD);
    chk("j3_len_sel", 128'(bus.o_ghash_sel),   128'd2);
    chk("j3_len_blk", 128'(bus.o_ghash_block), 128'h0000_0000_0000_0082_0000_0000_0000_0001);
    cyc(1'b0, 128'd0);
    cyc(1'b0, 128'd0);
    chk("j3_tag", 128'(bus.o_tag_ready), 128'd1);
    cyc(1'b0, 128'd0);

    // Job 4: aad=128, txt=128, valid on alternate cycles
    present(32'd128, 32'd128);
    cyc(1'b0, 128'd0);
    bus.i_desc_valid = 1'b0;
    chk("j4_new_inst", 128'(bus.o_new_instance), 128'd1);
    cyc(1'b0, 128'd0);
    chk("j4_bub0_gvalid", 128'(bus.o_ghash_valid), 128'd0);
    chk("j4_bub0_bready", 128'(bus.o_blk_ready),   128'd1);
    cyc(1'b1, 128'h0101_0101_0101_0101_0101_0101_0101_0101);
    chk("j4_a0_gvalid", 128'(bus.o_ghash_valid), 128'd1);
    chk("j4_a0_sel",    128'(bus.o_ghash_sel),   128'd0);
    chk("j4_a0_blk",    128'(bus.o_ghash_block), 128'h0101_0101_0101_0101_0101_0101_0101_0101);
    cyc(1'b0, 128'd0);
    chk("j4_bub1_gvalid", 128'(bus.o_ghash_valid), 128'd0);
    chk("j4_bub1_ctr",    128'(bus.o_ctr_en),      128'd0);
    cyc(1'b1, 128'h0202_0202_0202_0202_0202_0202_0202_0202);
    chk("j4_t0_sel", 128'(bus.o_ghash_sel),   128'd1);
    chk("j4_t0_blk", 128'(bus.o_ghash_block), 128'h0202_0202_0202_0202_0202_0202_0202_0202);
    chk("j4_t0_ctr", 128'(bus.o_ctr_en),      128'd1);
    cyc(1'b0, 128'd0);
    chk("j4_len_gvalid", 128'(bus.o_ghash_valid), 128'd1);
    chk("j4_len_blk",    128'(bus.o_ghash_block), 128'h0000_0000_0000_0080_0000_0000_0000_0080);
    cyc(1'b1, 128'd0);
    chk("j4_w1_tag", 128'(bus.o_tag_ready), 128'd0);
    cyc(1'b0, 128'd0);
    chk("j4_tag", 128'(bus.o_tag_ready), 128'd1);
    cyc(1'b0, 128'd0);

    // Job 5: reset during TEXT, then a clean aad=0, txt=128 job
    present(32'd0, 32'd256);
    cyc(1'b1, 128'h5555);
    bus.i_desc_valid = 1'b0;
    cyc(1'b1, 128'h5555);
    chk("j5_t0_ctr", 128'(bus.o_ctr_en), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("j5_rst_gvalid", 128'(bus.o_ghash_valid), 128'd0);
    chk("j5_rst_ctr",    128'(bus.o_ctr_en),      128'd0);
    chk("j5_rst_bready", 128'(bus.o_blk_ready),   128'd0);
    chk("j5_rst_busy",   128'(bus.o_busy),        128'd0);
    chk("j5_rst_dready", 128'(bus.o_desc_ready),  128'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 128'h5555);
    chk("j5_post_tag",  128'(bus.o_tag_ready), 128'd0);
    chk("j5_post_idle", 128'(bus.o_desc_ready), 128'd1);
    present(32'd0, 32'd128);
    cyc(1'b1, 128'h6666_0000_0000_0000_0000_0000_0000_0006);
    bus.i_desc_valid = 1'b0;
    chk("j5b_new_inst", 128'(bus.o_new_instance), 128'd1);
    cyc(1'b1, 128'h6666_0000_0000_0000_0000_0000_0000_0006);
    chk("j5b_t0_sel", 128'(bus.o_ghash_sel),   128'd1);
    chk("j5b_t0_blk", 128'(bus.o_ghash_block), 128'h6666_0000_0000_0000_0000_0000_0000_0006);
    cyc(1'b1, 128'd0);
    chk("j5b_len_blk", 128'(bus.o_ghash_block), 128'h0000_0000_0000_0000_0000_0000_0000_0080);
    cyc(1'b0, 128'd0);
    cyc(1'b0, 128'd0);
    chk("j5b_tag", 128'(bus.o_tag_ready), 128'd1);
    cyc(1'b0, 128'd0);

    // Job 6: descriptor held while busy is ignored until idle
    present(32'd128, 32'd0);
    cyc(1'b1, 128'h7777);
    present(32'd256, 32'd256);
    chk("j6_busy_dready", 128'(bus.o_desc_ready), 128'd0);
    cyc(1'b1, 128'h7777);
    chk("j6_a0_sel", 128'(bus.o_ghash_sel), 128'd0);
    cyc(1'b1, 128'h7777);
    chk("j6_len_blk", 128'(bus.o_ghash_block), 128'h0000_0000_0000_0080_0000_0000_0000_0000);
    cyc(1'b1, 128'h7777);
    chk("j6_w1_newi", 128'(bus.o_new_instance), 128'd0);
    cyc(1'b1, 128'h7777);
    chk("j6_tag",        128'(bus.o_tag_ready),  128'd1);
    chk("j6_tag_dready", 128'(bus.o_desc_ready), 128'd0);
    cyc(1'b1, 128'h7777);
    chk("j6_idle_dready", 128'(bus.o_desc_ready), 128'd1);
    cyc(1'b1, 128'h8888);
    bus.i_desc_valid = 1'b0;
    chk("j6b_new_inst", 128'(bus.o_new_instance), 128'd1);
    cyc(1'b1, 128'h8888);
    chk("j6b_a0_sel", 128'(bus.o_ghash_sel), 128'd0);
    cyc(1'b1, 128'h8888);
    chk("j6b_a1_sel", 128'(bus.o_ghash_sel), 128'd0);
    cyc(1'b1, 128'h8888);
    chk("j6b_t0_sel", 128'(bus.o_ghash_sel), 128'd1);
    cyc(1'b1, 128'h8888);
    chk("j6b_t1_sel", 128'(bus.o_ghash_sel), 128'd1);
    cyc(1'b1, 128'h8888);
    chk("j6b_len_blk", 128'(bus.o_ghash_block), 128'h0000_0000_0000_0100_0000_0000_0000_0100);
    cyc(1'b0, 128'd0);
    cyc(1'b0, 128'd0);
    chk("j6b_tag", 128'(bus.o_tag_ready), 128'd1);
    cyc(1'b0, 128'd0);
    chk("j6b_idle", 128'(bus.o_desc_ready), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
